// File: rtl/clk_en_pkg.sv
// clk_en_pkg: shared counter width and named divisor constants for clk_en_gen
// Contents: CLK_HZ system clock rate, CNT_W default counter width,
//           DIV_* divisors producing the named enable rates at CLK_HZ.
package clk_en_pkg;
  localparam int CLK_HZ    = 100_000_000;
  localparam int CNT_W     = 27;
  localparam int DIV_1HZ   = 100_000_000;
  localparam int DIV_2HZ   = 50_000_000;
  localparam int DIV_5HZ   = 20_000_000;
  localparam int DIV_200HZ = 500_000;
endpackage

// File: rtl/clk_en_chan.sv
// clk_en_chan: one enable channel, a wrapping counter with a staged runtime divisor
// Ports: clk, rst_n (async, active low), pause_i / sync_clr_i (shared controls),
//        we_i (decoded divisor write for this channel), cfg_div_i (new divisor),
//        en_o (registered one-cycle enable), tgl_o (only with CLK_EN_TOGGLE_EN).
module clk_en_chan import clk_en_pkg::*; #(
  parameter int CNT_W = clk_en_pkg::CNT_W,
  parameter logic [CNT_W-1:0] DEF = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pause_i,
  input  logic             sync_clr_i,
  input  logic             we_i,
  input  logic [CNT_W-1:0] cfg_div_i,
  output logic             en_o
`ifdef CLK_EN_TOGGLE_EN
  ,
  output logic             tgl_o
`endif
);
  logic [CNT_W-1:0] cnt_q, cnt_d, act_q, act_d, pend_q, pend_d, div_eff;
  logic pv_q, pv_d, en_q, en_d, run, wrap;
  assign div_eff = (act_q == '0) ? CNT_W'(1) : act_q;
  assign run = !pause_i && !sync_clr_i;
  // >= rather than == so a counter left beyond a shrunken divisor still wraps
  assign wrap = run && (cnt_q >= div_eff - CNT_W'(1));
  always_comb begin
    cnt_d = (sync_clr_i || wrap) ? '0 : run ? cnt_q + CNT_W'(1) : cnt_q;
    en_d = wrap;
    // a write landing on the wrap edge bypasses straight into the active divisor
    act_d = (wrap && we_i) ? cfg_div_i : ((wrap || sync_clr_i) && pv_q) ? pend_q : act_q;
    pend_d = we_i ? cfg_div_i : pend_q;
    pv_d = we_i ? !wrap : (wrap || sync_clr_i) ? 1'b0 : pv_q;
  end
`ifdef CLK_EN_TOGGLE_EN
  logic tgl_q, tgl_d;
  assign tgl_d = sync_clr_i ? 1'b0 : tgl_q ^ wrap;
  assign tgl_o = tgl_q;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      act_q <= DEF;
      pend_q <= DEF;
      pv_q <= 1'b0;
      en_q <= 1'b0;
`ifdef CLK_EN_TOGGLE_EN
      tgl_q <= 1'b0;
`endif
    end else begin
      cnt_q <= cnt_d;
      act_q <= act_d;
      pend_q <= pend_d;
      pv_q <= pv_d;
      en_q <= en_d;
`ifdef CLK_EN_TOGGLE_EN
      tgl_q <= tgl_d;
`endif
    end
  end
  assign en_o = en_q;
endmodule

// File: rtl/clk_en_gen.sv
// clk_en_gen: multi-channel clock-enable generator with runtime divisors, pause and resync
// Ports: clk, rst_n (async, active low), pause, sync_clr, cfg_we/cfg_ch/cfg_div
//        (divisor write, out-of-range cfg_ch ignored), en[NUM_CH] enable pulses.
// Option: define CLK_EN_TOGGLE_EN to add tgl[NUM_CH], a square wave flipping on each en.
module clk_en_gen import clk_en_pkg::*; #(
  parameter int NUM_CH = 4,
  parameter int CNT_W = clk_en_pkg::CNT_W,
  parameter logic [NUM_CH*CNT_W-1:0] DEF_DIV =
    {CNT_W'(DIV_5HZ), CNT_W'(DIV_200HZ), CNT_W'(DIV_2HZ), CNT_W'(DIV_1HZ)}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pause,
  input  logic              sync_clr,
  input  logic              cfg_we,
  input  logic [3:0]        cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic [NUM_CH-1:0] en
`ifdef CLK_EN_TOGGLE_EN
  ,
  output logic [NUM_CH-1:0] tgl
`endif
);
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    clk_en_chan #(
      .CNT_W(CNT_W),
      .DEF(DEF_DIV[c*CNT_W +: CNT_W])
    ) u_chan (
      .clk(clk),
      .rst_n(rst_n),
      .pause_i(pause),
      .sync_clr_i(sync_clr),
      .we_i(cfg_we && (cfg_ch == 4'(c))),
      .cfg_div_i(cfg_div),
      .en_o(en[c])
`ifdef CLK_EN_TOGGLE_EN
      ,
      .tgl_o(tgl[c])
`endif
    );
  end
endmodule

// File: tb/tb_clk_en_gen.sv
// tb_clk_en_gen: directed bench for clk_en_gen with a per-cycle period model plus literal pins
module tb_clk_en_gen;
  logic clk = 1'b0, rst_n = 1'b0, pause = 1'b0, sync_clr = 1'b0, cfg_we = 1'b0;
  logic [3:0] cfg_ch = '0;
  logic [7:0] cfg_div = '0;
  logic [3:0] en;
  int checks = 0, passed = 0;
  int cyc = 0;
  int per [4], rem [4], pend [4];
  bit pv [4];
  logic [3:0] exp_en, exp_tgl;
  localparam int DEFV [4] = '{5, 2, 3, 4};
`ifdef CLK_EN_TOGGLE_EN
  logic [3:0] tgl;
`endif

  clk_en_gen #(.NUM_CH(4), .CNT_W(8), .DEF_DIV({8'd4, 8'd3, 8'd2, 8'd5})) dut (
    .clk(clk), .rst_n(rst_n), .pause(pause), .sync_clr(sync_clr),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div), .en(en)
`ifdef CLK_EN_TOGGLE_EN
    , .tgl(tgl)
`endif
  );

  always #5 clk = ~clk;

  function automatic int eff(input int d);
    return d < 1 ? 1 : d;
  endfunction

  // Model: rem = run edges still to go before the next pulse; period reloads on pulse
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc = 0;
      exp_en = '0;
      exp_tgl = '0;
      for (int c = 0; c < 4; c++) begin
        per[c] = eff(DEFV[c]);
        rem[c] = per[c];
        pv[c] = 1'b0;
        pend[c] = DEFV[c];
      end
    end else begin
      cyc++;
      for (int c = 0; c < 4; c++) begin
        bit w;
        w = cfg_we && (int'(cfg_ch) == c);
        exp_en[c] = 1'b0;
        if (sync_clr) begin
          if (pv[c]) per[c] = eff(pend[c]);
          pv[c] = 1'b0;
          rem[c] = per[c];
          exp_tgl[c] = 1'b0;
          if (w) begin pend[c] = int'(cfg_div); pv[c] = 1'b1; end
        end else if (!pause && rem[c] == 1) begin
          exp_en[c] = 1'b1;
          exp_tgl[c] = ~exp_tgl[c];
          if (w) per[c] = eff(int'(cfg_div));
          else if (pv[c]) per[c] = eff(pend[c]);
          pv[c] = 1'b0;
          rem[c] = per[c];
        end else begin
          if (!pause) rem[c]--;
          if (w) begin pend[c] = int'(cfg_div); pv[c] = 1'b1; end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (en === exp_en) passed++;
      else $display("FAIL model_en cyc=%0d got=%b exp=%b", cyc, en, exp_en);
`ifdef CLK_EN_TOGGLE_EN
      checks++;
      if (tgl === exp_tgl) passed++;
      else $display("FAIL model_tgl cyc=%0d got=%b exp=%b", cyc, tgl, exp_tgl);
`endif
    end
  end

  task automatic lit(input string name, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s cyc=%0d got=%b exp=%b", name, cyc, got, exp);
  endtask

  task automatic wait_cyc(input int k);
    int n = 0;
    while (cyc < k && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n == 1000) begin
      checks++;
      $display("FAIL wait_cyc got=%0d exp=%0d", cyc, k);
    end
  endtask

  task automatic wr(input logic [3:0] ch, input logic [7:0] d);
    cfg_we = 1'b1;
    cfg_ch = ch;
    cfg_div = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    lit("reset_en", en, 4'b0000);
    rst_n = 1'b1;
    wait_cyc(5);  lit("first_c5", en, 4'b0001);
    wait_cyc(6);  lit("first_c6", en, 4'b0110);
    wait_cyc(12); lit("first_c12", en, 4'b1110);
    wait_cyc(20); lit("first_c20", en, 4'b1011);
    wait_cyc(62);
    cfg_we = 1'b1; cfg_ch = 4'd0; cfg_div = 8'd8;
    @(negedge clk);
    cfg_ch = 4'd7; cfg_div = 8'd1;
    @(negedge clk);
    cfg_we = 1'b0;
    wait_cyc(65); lit("div8_keep_c65", {3'b0, en[0]}, 4'b0001);
    wait_cyc(70); lit("div8_c70", {3'b0, en[0]}, 4'b0000);
    wait_cyc(73); lit("div8_c73", {3'b0, en[0]}, 4'b0001);
    wait_cyc(81);
    wr(4'd1, 8'd0);
    wait_cyc(83); lit("div0_c83", {3'b0, en[1]}, 4'b0001);
    wait_cyc(84); lit("div0_c84", {3'b0, en[1]}, 4'b0001);
    wait_cyc(85);
    wr(4'd1, 8'd1);
    wait_cyc(87); lit("div1_c87", {3'b0, en[1]}, 4'b0001);
    wait_cyc(88);
    pause = 1'b1;
    wait_cyc(89); lit("pause_c89", en, 4'b0000);
    wait_cyc(91);
    pause = 1'b0;
    wait_cyc(92); lit("resume_c92", en, 4'b0011);
    wr(4'd0, 8'd5);
    wait_cyc(100); lit("div5_c100", {3'b0, en[0]}, 4'b0001);
    wait_cyc(103);
    pause = 1'b1;
    wait_cyc(105); lit("paused_c105", en, 4'b0000);
    wait_cyc(113);
    pause = 1'b0;
    wait_cyc(114); lit("resume_c114", {3'b0, en[0]}, 4'b0000);
    wait_cyc(115); lit("resume_c115", {3'b0, en[0]}, 4'b0001);
    wait_cyc(120); lit("resume_c120", {3'b0, en[0]}, 4'b0001);
    wait_cyc(125);
    wr(4'd2, 8'd4);
    wr(4'd3, 8'd6);
    wait_cyc(150);
    wr(4'd0, 8'd3);
    wait_cyc(152);
    sync_clr = 1'b1;
    @(negedge clk);
    sync_clr = 1'b0;
    lit("sync_c153", en, 4'b0000);
    wait_cyc(154); lit("sync_c154", en, 4'b0010);
    wait_cyc(156); lit("sync_c156", en, 4'b0011);
    wait_cyc(157); lit("sync_c157", en, 4'b0110);
    wait_cyc(158); lit("sync_c158", en, 4'b0010);
    wait_cyc(159); lit("sync_c159", en, 4'b1011);
    wait_cyc(165);
    #2 rst_n = 1'b0;
    #1 lit("async_rst_en", en, 4'b0000);
`ifdef CLK_EN_TOGGLE_EN
    lit("async_rst_tgl", tgl, 4'b0000);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    wait_cyc(5); lit("rerst_c5", en, 4'b0001);
`ifdef CLK_EN_TOGGLE_EN
    lit("tgl_c5", tgl, 4'b1101);
`endif
    wait_cyc(6); lit("rerst_c6", en, 4'b0110);
    wait_cyc(10);
`ifdef CLK_EN_TOGGLE_EN
    lit("tgl_c10", tgl, 4'b0110);
`endif
    wait_cyc(12);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end
endmodule
